// File: rtl/pipeline_hazard_ctrl_pkg.sv
// Shared types for the pipeline hazard controller: controller state encoding
// and the fixed latch indices the hazard rules refer to.
package pipeline_hazard_ctrl_pkg;

    typedef enum logic [1:0] {
        RUN   = 2'd0,
        DWAIT = 2'd1,
        HALT  = 2'd2
    } hazard_state_t;

    localparam int IF_ID = 0;
    localparam int ID_EX = 1;

endpackage

// File: rtl/pipeline_hazard_ctrl_if.sv
// Bundle between the hazard controller and the datapath: hit/hazard inputs
// in, per-latch enable/flush, PC enable and status out.
interface pipeline_hazard_ctrl_if #(
    parameter int NLATCH = 4,
    parameter int CNT_W  = 16
) ();

    logic              ihit;
    logic              dhit;
    logic              dmem_req;
    logic              load_use;
    logic              branch_taken;
    logic              halt;
    logic [NLATCH-1:0] enable;
    logic [NLATCH-1:0] flush;
    logic              pc_en;
    logic              halted;
    logic              mem_timeout;
    logic [CNT_W-1:0]  stall_count;

    modport ctrl (
        input  ihit, dhit, dmem_req, load_use, branch_taken, halt,
        output enable, flush, pc_en, halted, mem_timeout, stall_count
    );

    modport dp (
        output ihit, dhit, dmem_req, load_use, branch_taken, halt,
        input  enable, flush, pc_en, halted, mem_timeout, stall_count
    );

endinterface

// File: rtl/pipeline_hazard_ctrl.sv
// Hazard controller for an NLATCH-deep in-order pipeline: combinational
// enable/flush/pc_en from hits and hazards, plus RUN/DWAIT/HALT tracking,
// a saturating stall counter and a sticky data-memory watchdog.
module pipeline_hazard_ctrl
    import pipeline_hazard_ctrl_pkg::*;
#(
    parameter int          NLATCH  = 4,
    parameter int          MEM_IDX = 2,
    parameter int          BR_IDX  = 2,
    parameter int          CNT_W   = 16,
    parameter int unsigned TIMEOUT = 0
) (
    input  logic                 CLK,
    input  logic                 nRST,
    pipeline_hazard_ctrl_if.ctrl bus,
    output hazard_state_t        state_o
);

    localparam logic [CNT_W-1:0] CNT_MAX  = '1;
    localparam logic [31:0]      WAIT_MAX = TIMEOUT;

    hazard_state_t     state_q, state_d;
    logic [CNT_W-1:0]  stall_q, stall_d;
    logic [31:0]       wait_q, wait_d;
    logic              halted_q, halted_d;
    logic              timeout_q, timeout_d;
    logic [NLATCH-1:0] en_c, fl_c;
    logic              pc_c;
    logic              mem_stall;

    assign mem_stall = bus.dmem_req & ~bus.dhit;

    // Hazard priority: memory stall > memory done without fetch > fetch miss
    // > taken branch > load-use > normal advance.
    always_comb begin
        en_c    = '0;
        fl_c    = '0;
        pc_c    = 1'b0;
        state_d = state_q;
        if (!nRST) begin
            fl_c    = '1;
            state_d = RUN;
        end else if (state_q != HALT) begin
            if (mem_stall) begin
                for (int i = 0; i < NLATCH; i++) begin
                    en_c[i] = (i > MEM_IDX);
                end
                fl_c[MEM_IDX+1] = 1'b1;
            end else if (bus.dmem_req && !bus.ihit) begin
                en_c        = '1;
                fl_c[IF_ID] = 1'b1;
            end else if (!bus.ihit) begin
                en_c = '0;
            end else if (bus.branch_taken) begin
                en_c = '1;
                for (int i = 0; i < NLATCH; i++) begin
                    fl_c[i] = (i < BR_IDX);
                end
                pc_c = 1'b1;
            end else if (bus.load_use) begin
                en_c        = '1;
                en_c[IF_ID] = 1'b0;
                fl_c[ID_EX] = 1'b1;
            end else begin
                en_c = '1;
                pc_c = 1'b1;
            end

            // A halt seen during a memory stall waits for the access to finish.
            if (mem_stall) begin
                state_d = DWAIT;
            end else if (bus.halt) begin
                state_d = HALT;
            end else begin
                state_d = RUN;
            end
        end
    end

    always_comb begin
        stall_d   = stall_q;
        wait_d    = '0;
        halted_d  = halted_q | (state_d == HALT);
        timeout_d = timeout_q;
        if (state_q != HALT && !pc_c && stall_q != CNT_MAX) begin
            stall_d = stall_q + CNT_W'(1);
        end
        if (state_q != HALT && mem_stall) begin
            wait_d = (wait_q < WAIT_MAX) ? wait_q + 32'd1 : wait_q;
        end
        // The watchdog only flags; the pipeline keeps waiting for dhit.
        if (WAIT_MAX != 32'd0 && wait_d == WAIT_MAX) begin
            timeout_d = 1'b1;
        end
    end

    always_ff @(posedge CLK) begin
        if (!nRST) begin
            state_q   <= RUN;
            stall_q   <= '0;
            wait_q    <= '0;
            halted_q  <= 1'b0;
            timeout_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            stall_q   <= stall_d;
            wait_q    <= wait_d;
            halted_q  <= halted_d;
            timeout_q <= timeout_d;
        end
    end

    assign bus.enable      = en_c;
    assign bus.flush       = fl_c;
    assign bus.pc_en       = pc_c;
    assign bus.halted      = halted_q;
    assign bus.mem_timeout = timeout_q;
    assign bus.stall_count = stall_q;
    assign state_o         = state_q;

endmodule

// File: doc/pipeline_hazard_ctrl.md
Name: pipeline_hazard_ctrl

Overview:
- Parametrised successor to the fixed four-latch pipeline controller. Drives per-latch enable/flush vectors for an NLATCH-latch in-order pipeline from ihit/dhit, load-use, branch-taken and halt.
- Adds a RUN/DWAIT/HALT state machine, a saturating stall counter, a sticky halted flag and a data-memory timeout watchdog.
- Sits beside the datapath. Its outputs feed every pipeline latch and the PC enable.

Parameters:
- NLATCH, 4: number of pipeline latches. Index 0 is IF/ID, index NLATCH-1 is last. Legal range 2..8.
- MEM_IDX, 2: index of the latch holding the memory-stage instruction. Must satisfy MEM_IDX < NLATCH-1.
- BR_IDX, 2: branch resolves in the stage fed by latch BR_IDX-1. On taken, latches 0..BR_IDX-1 are flushed. Range 1..MEM_IDX.
- CNT_W, 16: stall counter width.
- TIMEOUT, 0: maximum consecutive DWAIT cycles before mem_timeout is raised. 0 disables the watchdog.

Ports:
- CLK  in  1  clock, rising edge.
- nRST  in  1  reset, synchronous active-low.
- ihit  in  1  instruction memory returned the fetch this cycle.
- dhit  in  1  data memory completed the access this cycle.
- dmem_req  in  1  latch MEM_IDX holds a load or store (dREN|dWEN).
- load_use  in  1  a load in latch 0's successor conflicts with a source of the instruction in latch 0.
- branch_taken  in  1  a taken branch or jump is resolved this cycle.
- halt  in  1  a halt instruction is in latch NLATCH-1.
- enable  out  NLATCH  per-latch load enable.
- flush  out  NLATCH  per-latch bubble insert. Flush overrides enable at the latch.
- pc_en  out  1  PC register update enable.
- halted  out  1  sticky halt status.
- mem_timeout  out  1  sticky watchdog flag.
- stall_count  out  CNT_W  saturating count of cycles with pc_en=0 while not halted.

Behaviour:
- Reset: one clock synchronous with nRST=0. State=RUN; halted=0; mem_timeout=0; stall_count=0; wait counter=0. During reset, enable=0, flush=all-ones, pc_en=0. Reset mid-DWAIT abandons the wait; no event survives reset.
- enable, flush and pc_en are combinational from the inputs and the state, with zero-cycle latency. halted, mem_timeout and stall_count are registered.
- Define mem_stall = dmem_req & ~dhit.

State RUN and DWAIT, evaluated in priority order:
1. mem_stall:
   - enable[0..MEM_IDX]=0.
   - flush[MEM_IDX+1]=1, so no duplicate writeback.
   - Latches above MEM_IDX+1 advance.
   - pc_en=0. branch_taken and load_use are ignored this cycle because they are held frozen.
2. dmem_req & dhit & ~ihit:
   - All enables=1.
   - flush[0]=1, so no fetched instruction enters.
   - pc_en=0.
3. ~ihit (no dmem_req): all enables=0, flush=0, pc_en=0.
4. branch_taken:
   - All enables=1.
   - flush[0..BR_IDX-1]=1.
   - pc_en=1, so the PC loads the target.
   - branch_taken with load_use: the branch wins and the load-use is dropped.
5. load_use:
   - enable[0]=0 and pc_en=0.
   - flush[1]=1.
   - Latches 2.. advance.
6. Otherwise: all enables=1, flush=0, pc_en=1.

State transitions:
- RUN→DWAIT on mem_stall.
- DWAIT→RUN on dhit.
- Any state→HALT when halt=1 and the stall cases above do not apply. Halt asserted during mem_stall is deferred until dhit.
- HALT is terminal until reset.
- HALT outputs: enable=0, flush=0, pc_en=0, halted=1.

Watchdog:
- The wait counter increments each DWAIT cycle and clears on leaving DWAIT.
- When TIMEOUT≠0 and the counter reaches TIMEOUT, mem_timeout is set. It is sticky and purely a flag: the pipeline keeps waiting.

Stall counter:
- stall_count increments on each cycle with pc_en=0 in RUN or DWAIT.
- It saturates at 2^CNT_W-1 with no wrap.
- It freezes in HALT.

Decomposition:
- Add to cpu_types_pkg:
  - typedef enum logic [1:0] {RUN, DWAIT, HALT} hazard_state_t;
  - localparams IF_ID=0 and ID_EX=1 for the latch indices.
- Add pipeline_hazard_ctrl_if.vh with a parametrised interface and modports for the controller and the datapath.
- No sub-module is needed; the watchdog counter stays inline.

Test Plan:
1. Reset, then ihit=1 and all other inputs 0 for 3 cycles → enable=4'b1111, flush=0, pc_en=1, stall_count=0.
2. dmem_req=1, dhit=0 for 3 cycles, then dhit=1, ihit=0 → 3 cycles of enable=4'b1000 and flush=4'b1000 in DWAIT. Next cycle enable=4'b1111, flush=4'b0001, RUN. stall_count=4.
3. ihit=1, load_use=1 and branch_taken=1 in the same cycle → branch wins: flush=4'b0011, pc_en=1. Next cycle load_use alone → enable[0]=0, flush=4'b0010, pc_en=0.
4. TIMEOUT=5, dmem_req=1, dhit=0 for 7 cycles → mem_timeout rises after the 5th DWAIT cycle and stays 1 after dhit.
5. halt=1 during mem_stall, dhit after 2 cycles → the halt is taken on the dhit cycle. From the next cycle halted=1 and enable=0, and stall_count is frozen. Asserting nRST=0 for 1 cycle clears everything.
6. NLATCH=5, MEM_IDX=3, BR_IDX=1: mem_stall → enable=5'b10000, flush=5'b10000. branch_taken → flush=5'b00001.
